// File: rtl/byte_pack_pkg.sv
// Shared types and width helpers for the byte-to-word packer.
// Entries are stored flat as {keep, data}.
package byte_pack_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FILL  = 1'b1
  } pack_state_e;

  function automatic int data_w(input int bpw);
    return bpw * BYTE_W;
  endfunction

  function automatic int keep_w(input int bpw);
    return bpw;
  endfunction

  function automatic int entry_w(input int bpw);
    return data_w(bpw) + keep_w(bpw);
  endfunction

endpackage

// File: rtl/pack_fifo.sv
// Synchronous FIFO of packed word entries.
// Pointers carry an extra wrap bit to tell full from empty.
module pack_fifo
  import byte_pack_pkg::*;
#(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) &&
              (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    head    = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/byte_word_packer.sv
// Packs an unthrottled byte stream into little-endian words,
// buffers them and counts words lost to a full output FIFO.
module byte_word_packer
  import byte_pack_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [7:0]                       in_data,
  input  logic                             in_valid,
  input  logic                             flush,
  output logic [8*BYTES_PER_WORD-1:0]      out_data,
  output logic [BYTES_PER_WORD-1:0]        out_keep,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             overflow,
  input  logic                             ovf_clr,
  output logic [15:0]                      drop_count
);

  localparam int BPW = BYTES_PER_WORD;
  localparam int DW  = data_w(BPW);
  localparam int KW  = keep_w(BPW);
  localparam int EW  = entry_w(BPW);
  localparam int IW  = $clog2(BPW);

  pack_state_e   state_q, state_d;
  logic [IW-1:0] byte_idx_q, byte_idx_d;
  logic [DW-1:0] acc_data_q, acc_data_d;
  logic [KW-1:0] acc_keep_q, acc_keep_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_count_q, drop_count_d;

  logic [DW-1:0] word_data;
  logic [KW-1:0] word_keep;
  logic          last;
  logic          do_push;
  logic          pop;
  logic          drop;
  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] fifo_head;

  // Merge this cycle's byte into the word so flush sees it.
  always_comb begin
    word_data = acc_data_q;
    word_keep = acc_keep_q;
    for (int i = 0; i < BPW; i++) begin
      if (in_valid && byte_idx_q == IW'(i)) begin
        word_data[i*BYTE_W +: BYTE_W] = in_data;
        word_keep[i] = 1'b1;
      end
    end
  end

  always_comb begin
    last      = in_valid &&
                (byte_idx_q == IW'(BPW - 1));
    do_push   = last ||
                (flush && (state_q == FILL || in_valid));
    pop       = !fifo_empty && out_ready;
    drop      = do_push && fifo_full && !pop;
    fifo_push = do_push && !drop;

    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    acc_data_d = acc_data_q;
    acc_keep_d = acc_keep_q;
    if (do_push) begin
      state_d    = EMPTY;
      byte_idx_d = '0;
      acc_data_d = '0;
      acc_keep_d = '0;
    end else if (in_valid) begin
      state_d    = FILL;
      byte_idx_d = byte_idx_q + IW'(1);
      acc_data_d = word_data;
      acc_keep_d = word_keep;
    end

    // A drop in the same cycle as a clear keeps the flag set.
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;

    drop_count_d = drop_count_q;
    if (drop && drop_count_q != 16'hFFFF)
      drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      byte_idx_q   <= '0;
      acc_data_q   <= '0;
      acc_keep_q   <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      acc_data_q   <= acc_data_d;
      acc_keep_q   <= acc_keep_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  pack_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({word_keep, word_data}),
    .pop   (out_ready),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_data   = fifo_head[DW-1:0];
  assign out_keep   = fifo_head[EW-1:DW];
  assign out_valid  = !fifo_empty;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// Bench for byte_word_packer: vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_byte_word_packer;

  localparam int BPW   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        overflow;
  logic [15:0] drop_count;

  byte_word_packer #(
    .BYTES_PER_WORD (BPW),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .flush      (flush),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  pend [$];
  logic [35:0] mq [$];
  bit          m_ovf;
  int          m_cnt;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        f;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ek;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(
    input logic v, input logic [7:0] d, input logic f,
    input logic ev, input logic [31:0] ed, input logic [3:0] ek);
    vec_t r;
    r.v = v; r.d = d; r.f = f;
    r.ev = ev; r.ed = ed; r.ek = ek;
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] seq_word(input int first);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < BPW; i++)
      w[8*i +: 8] = 8'(first + i);
    return w;
  endfunction

  // Reference: bytes collect in a list; a word forms when the list
  // reaches BPW or a flush finds it non-empty.
  task automatic model_step();
    bit          pop;
    bit          was_full;
    bit          dropped;
    bit          pushed;
    logic [31:0] wd;
    logic [3:0]  wk;
    pop      = (mq.size() > 0) && out_ready;
    was_full = (mq.size() == DEPTH);
    dropped  = 0;
    pushed   = 0;
    wd = '0;
    wk = '0;
    if (in_valid) pend.push_back(in_data);
    if (pend.size() == BPW || (flush && pend.size() > 0)) begin
      foreach (pend[i]) begin
        wd = wd | (32'(pend[i]) << (8 * i));
        wk[i] = 1'b1;
      end
      pend.delete();
      if (was_full && !pop) begin
        dropped = 1;
        m_ovf = 1;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        pushed = 1;
      end
    end
    if (!dropped && ovf_clr) m_ovf = 0;
    if (pop) void'(mq.pop_front());
    if (pushed) mq.push_back({wk, wd});
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_data", out_data, mq[0][31:0]);
      chk("out_keep", 32'(out_keep), 32'(mq[0][35:32]));
    end
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_cnt[15:0]));
  endtask

  task automatic apply(input logic v, input logic [7:0] d,
                       input logic f, input logic r,
                       input logic c);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    ovf_clr   = c;
    @(posedge clk);
    #1;
    model_step();
    check_outputs();
  endtask

  task automatic model_clear();
    pend.delete();
    mq.delete();
    m_ovf = 0;
    m_cnt = 0;
  endtask

  task automatic do_reset();
    in_valid = 0; flush = 0; out_ready = 0; ovf_clr = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_clear();
  endtask

  initial begin
    model_clear();
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", out_data, 0);
    chk("rst_keep", 32'(out_keep), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_cnt", 32'(drop_count), 0);
    do_reset();

    tbl.push_back(mk(1, 8'h01, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h02, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h03, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h04, 0, 1, 32'h04030201, 4'hF));
    tbl.push_back(mk(1, 8'h05, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h06, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h07, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h08, 0, 1, 32'h08070605, 4'hF));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'hBB, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 32'h0000BBAA, 4'h3));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'hCC, 1, 1, 32'h000000CC, 4'h1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h21, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h22, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h23, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h24, 1, 1, 32'h24232221, 4'hF));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].d, tbl[i].f, 1'b1, 1'b0);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid),
          32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
        chk($sformatf("tbl%0d_keep", i), 32'(out_keep),
            32'(tbl[i].ek));
      end
    end

    // Overflow: 20 bytes with no drain, word 5 is lost.
    do_reset();
    for (int i = 1; i <= 20; i++) apply(1, 8'(i), 0, 0, 0);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_cnt", 32'(drop_count), 1);
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("drain%0d", w), out_data, seq_word(4*w + 1));
      apply(0, 0, 0, 1, 0);
    end
    chk("drain_empty", 32'(out_valid), 0);

    // Pop on the same edge as the push into a full FIFO.
    do_reset();
    for (int i = 1; i <= 19; i++) apply(1, 8'(i), 0, 0, 0);
    apply(1, 8'd20, 0, 1, 0);
    chk("nodrop_cnt", 32'(drop_count), 0);
    chk("nodrop_ovf", 32'(overflow), 0);
    chk("nodrop_head", out_data, seq_word(5));
    repeat (5) apply(0, 0, 0, 1, 0);

    // Clear racing a new drop.
    do_reset();
    for (int i = 1; i <= 20; i++) apply(1, 8'(i), 0, 0, 0);
    apply(0, 0, 0, 0, 1);
    chk("clr_ovf", 32'(overflow), 0);
    for (int i = 21; i <= 23; i++) apply(1, 8'(i), 0, 0, 0);
    apply(1, 8'd24, 0, 0, 1);
    chk("clr_race_ovf", 32'(overflow), 1);
    chk("clr_race_cnt", 32'(drop_count), 2);

    // Asynchronous reset with 3 words and 2 bytes pending.
    do_reset();
    for (int i = 1; i <= 14; i++) apply(1, 8'(i), 0, 0, 0);
    #3;
    rst_n = 0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data", out_data, 0);
    chk("arst_keep", 32'(out_keep), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_cnt", 32'(drop_count), 0);
    model_clear();
    in_valid = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 8'h11; i <= 8'h14; i++) apply(1, 8'(i), 0, 0, 0);
    chk("arst_word", out_data, 32'h14131211);
    chk("arst_wkeep", 32'(out_keep), 4'hF);
    apply(0, 0, 0, 1, 0);
    chk("arst_only", 32'(out_valid), 0);

    // Randomized traffic with alternating drain pressure.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(9, 0) < 7,
            8'($urandom),
            $urandom_range(9, 0) == 0,
            ((i / 60) % 2 == 1) ? ($urandom_range(1, 0) == 1)
                                : ($urandom_range(7, 0) == 0),
            $urandom_range(19, 0) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
